// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: two-master native memory bus arbiter with a bus-timeout watchdog
module mem_bus_arbiter #(
    parameter bit          ROUND_ROBIN    = 1'b1,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        m0_valid,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic        m0_ready,
    output logic [31:0] m0_rdata,
    input  logic        m1_valid,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic        m1_ready,
    output logic [31:0] m1_rdata,
    output logic        s_valid,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    input  logic        s_ready,
    input  logic [31:0] s_rdata,
    output logic [1:0]  grant,
    output logic        bus_err,
    output logic [31:0] err_addr,
    input  logic        err_clr
);
    typedef enum logic [1:0] {IDLE = 2'b00, G0 = 2'b01, G1 = 2'b10} state_t;
    localparam bit          TO_EN   = TIMEOUT_CYCLES != 0;
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
    state_t      state, state_nx;
    logic        last_m1;
    logic [15:0] cnt;
    logic        sel0, sel1, req, expire, fin;
    logic [31:0] rdata_g;
    assign sel0     = state == G0;
    assign sel1     = state == G1;
    assign req      = (sel0 && m0_valid) || (sel1 && m1_valid);
    assign expire   = TO_EN && req && !s_ready && cnt == TO_LAST;
    assign fin      = req && (s_ready || expire);
    assign grant    = state;
    assign s_valid  = req && !expire;
    assign s_addr   = sel0 ? m0_addr : sel1 ? m1_addr : '0;
    assign s_wdata  = sel0 ? m0_wdata : sel1 ? m1_wdata : '0;
    assign s_wstrb  = sel0 ? m0_wstrb : sel1 ? m1_wstrb : '0;
    assign rdata_g  = expire ? ERR_RDATA : s_rdata;
    assign m0_ready = sel0 && fin;
    assign m1_ready = sel1 && fin;
    assign m0_rdata = sel0 ? rdata_g : '0;
    assign m1_rdata = sel1 ? rdata_g : '0;
    always_comb begin
        state_nx = state;
        if (state == IDLE)
            state_nx = (m0_valid && m1_valid) ? ((ROUND_ROBIN && !last_m1) ? G1 : G0) :
                       m0_valid ? G0 : m1_valid ? G1 : IDLE;
        else if (!req || fin)
            state_nx = IDLE;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            last_m1  <= 1'b1;
            cnt      <= '0;
            bus_err  <= 1'b0;
            err_addr <= '0;
        end else begin
            state <= state_nx;
            cnt   <= (state != IDLE && state_nx != IDLE) ? cnt + 16'd1 : '0;
            if (fin)
                last_m1 <= sel1;
            if (err_clr) begin
                bus_err  <= 1'b0;
                err_addr <= '0;
            end
            if (expire) begin
                bus_err <= 1'b1;
                if (!bus_err || err_clr)
                    err_addr <= s_addr;
            end
        end
    end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: round-robin and fixed-priority arbiters checked against a transaction-level model
module tb_mem_bus_arbiter;
    localparam int          TO  = 8;
    localparam logic [31:0] ERR = 32'hDEAD_BEEF;

    typedef struct packed {
        logic        sv;
        logic [31:0] sa;
        logic [31:0] sw;
        logic [3:0]  ss;
        logic        r0;
        logic [31:0] d0;
        logic        r1;
        logic [31:0] d1;
        logic [1:0]  g;
        logic        be;
        logic [31:0] ea;
    } out_t;

    typedef struct {
        int          owner;
        int          waited;
        int          last;
        bit          err;
        logic [31:0] eaddr;
    } mst_t;

    logic        clk = 1'b0, reset_n = 1'b1;
    logic        m0_valid = 1'b0, m1_valid = 1'b0, err_clr = 1'b0;
    logic [31:0] m0_addr = '0, m0_wdata = '0, m1_addr = '0, m1_wdata = '0, s_rdata = '0;
    logic [3:0]  m0_wstrb = '0, m1_wstrb = '0;
    logic        s_ready;

    logic        a_m0_ready, a_m1_ready, a_s_valid, a_bus_err;
    logic [31:0] a_m0_rdata, a_m1_rdata, a_s_addr, a_s_wdata, a_err_addr;
    logic [3:0]  a_s_wstrb;
    logic [1:0]  a_grant;
    logic        b_m0_ready, b_m1_ready, b_s_valid, b_bus_err;
    logic [31:0] b_m0_rdata, b_m1_rdata, b_s_addr, b_s_wdata, b_err_addr;
    logic [3:0]  b_s_wstrb;
    logic [1:0]  b_grant;

    int   checks = 0, failures = 0;
    bit   run = 1'b0;
    int   slave_lat = 0, gcnt;
    bit   slave_en = 1'b0, slave_sel = 1'b0;
    logic [1:0] sel_grant;
    mst_t ma, mb;
    out_t act_a, act_b;
    logic [1:0] gseq [4];
    int   ns, m1_grants;

    mem_bus_arbiter #(.ROUND_ROBIN(1'b1), .TIMEOUT_CYCLES(TO)) dut_rr (
        .clk(clk), .reset_n(reset_n),
        .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
        .m0_ready(a_m0_ready), .m0_rdata(a_m0_rdata),
        .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
        .m1_ready(a_m1_ready), .m1_rdata(a_m1_rdata),
        .s_valid(a_s_valid), .s_addr(a_s_addr), .s_wdata(a_s_wdata), .s_wstrb(a_s_wstrb),
        .s_ready(s_ready), .s_rdata(s_rdata),
        .grant(a_grant), .bus_err(a_bus_err), .err_addr(a_err_addr), .err_clr(err_clr)
    );

    mem_bus_arbiter #(.ROUND_ROBIN(1'b0), .TIMEOUT_CYCLES(TO)) dut_fp (
        .clk(clk), .reset_n(reset_n),
        .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
        .m0_ready(b_m0_ready), .m0_rdata(b_m0_rdata),
        .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
        .m1_ready(b_m1_ready), .m1_rdata(b_m1_rdata),
        .s_valid(b_s_valid), .s_addr(b_s_addr), .s_wdata(b_s_wdata), .s_wstrb(b_s_wstrb),
        .s_ready(s_ready), .s_rdata(s_rdata),
        .grant(b_grant), .bus_err(b_bus_err), .err_addr(b_err_addr), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    // slave acks slave_lat cycles into the selected arbiter's grant; keyed off grant to avoid a loop through s_valid
    assign sel_grant = slave_sel ? b_grant : a_grant;
    assign s_ready   = slave_en && sel_grant != 2'b00 && gcnt == slave_lat;
    always @(posedge clk or negedge reset_n)
        if (!reset_n) gcnt <= 0;
        else gcnt <= (sel_grant != 2'b00 && !s_ready) ? gcnt + 1 : 0;

    assign act_a = {a_s_valid, a_s_addr, a_s_wdata, a_s_wstrb, a_m0_ready, a_m0_rdata,
                    a_m1_ready, a_m1_rdata, a_grant, a_bus_err, a_err_addr};
    assign act_b = {b_s_valid, b_s_addr, b_s_wdata, b_s_wstrb, b_m0_ready, b_m0_rdata,
                    b_m1_ready, b_m1_rdata, b_grant, b_bus_err, b_err_addr};

    function automatic mst_t model_reset();
        mst_t m;
        m.owner = 0; m.waited = 0; m.last = 2; m.err = 1'b0; m.eaddr = '0;
        return m;
    endfunction

    function automatic out_t predict(mst_t m);
        out_t o;
        logic req, expired;
        logic [31:0] rd;
        o = '0;
        o.g  = m.owner == 1 ? 2'b01 : m.owner == 2 ? 2'b10 : 2'b00;
        o.be = m.err;
        o.ea = m.eaddr;
        if (m.owner != 0) begin
            req     = m.owner == 1 ? m0_valid : m1_valid;
            expired = req && !s_ready && m.waited == TO - 1;
            o.sv    = req && !expired;
            o.sa    = m.owner == 1 ? m0_addr : m1_addr;
            o.sw    = m.owner == 1 ? m0_wdata : m1_wdata;
            o.ss    = m.owner == 1 ? m0_wstrb : m1_wstrb;
            rd      = expired ? ERR : s_rdata;
            if (m.owner == 1) begin o.r0 = req && (s_ready || expired); o.d0 = rd; end
            else begin o.r1 = req && (s_ready || expired); o.d1 = rd; end
        end
        return o;
    endfunction

    function automatic mst_t step(mst_t m, bit rr);
        mst_t n;
        logic req, expired;
        n = m;
        if (err_clr) begin n.err = 1'b0; n.eaddr = '0; end
        if (m.owner == 0) begin
            n.waited = 0;
            if (m0_valid && m1_valid) n.owner = (rr && m.last == 1) ? 2 : 1;
            else n.owner = m0_valid ? 1 : m1_valid ? 2 : 0;
        end else begin
            req     = m.owner == 1 ? m0_valid : m1_valid;
            expired = req && !s_ready && m.waited == TO - 1;
            if (expired) begin
                n.err = 1'b1;
                if (!m.err || err_clr) n.eaddr = m.owner == 1 ? m0_addr : m1_addr;
            end
            if (!req || s_ready || expired) begin
                if (req) n.last = m.owner;
                n.owner  = 0;
                n.waited = 0;
            end else n.waited = m.waited + 1;
        end
        return n;
    endfunction

    always @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            ma <= model_reset();
            mb <= model_reset();
        end else begin
            ma <= step(ma, 1'b1);
            mb <= step(mb, 1'b0);
        end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic cmp(input string t, input out_t a, input out_t e);
        chk({t, ".s_valid"},  32'(a.sv), 32'(e.sv));
        chk({t, ".s_addr"},   a.sa, e.sa);
        chk({t, ".s_wdata"},  a.sw, e.sw);
        chk({t, ".s_wstrb"},  32'(a.ss), 32'(e.ss));
        chk({t, ".m0_ready"}, 32'(a.r0), 32'(e.r0));
        chk({t, ".m0_rdata"}, a.d0, e.d0);
        chk({t, ".m1_ready"}, 32'(a.r1), 32'(e.r1));
        chk({t, ".m1_rdata"}, a.d1, e.d1);
        chk({t, ".grant"},    32'(a.g), 32'(e.g));
        chk({t, ".bus_err"},  32'(a.be), 32'(e.be));
        chk({t, ".err_addr"}, a.ea, e.ea);
    endtask

    always @(negedge clk)
        if (run) begin
            cmp("rr", act_a, predict(ma));
            cmp("fp", act_b, predict(mb));
        end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_all();
        reset_n  = 1'b0;
        m0_valid = 1'b0;
        m1_valid = 1'b0;
        err_clr  = 1'b0;
        slave_en = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic wait_done(input bit m1, output int n, output logic [31:0] rd);
        n = 0;
        @(negedge clk);
        while (!(m1 ? a_m1_ready : a_m0_ready) && n < 40) begin
            n++;
            @(negedge clk);
        end
        if (n >= 40) begin
            checks++;
            failures++;
            $display("FAIL wait_done actual=no_ready required=ready");
        end
        rd = m1 ? a_m1_rdata : a_m0_rdata;
        tick();
        if (m1) m1_valid = 1'b0;
        else m0_valid = 1'b0;
    endtask

    task automatic run_contention(input bit use_b);
        logic [1:0] prev, g;
        prev = 2'b00;
        ns = 0;
        m1_grants = 0;
        for (int i = 0; i < 4; i++) gseq[i] = 2'b00;
        m0_valid = 1'b1;
        m1_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            g = use_b ? b_grant : a_grant;
            if (g != 2'b00 && prev == 2'b00 && ns < 4) begin
                gseq[ns] = g;
                ns++;
            end
            if (g == 2'b10) m1_grants++;
            prev = g;
        end
        tick();
        m0_valid = 1'b0;
        m1_valid = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        int n, nrdy, at;
        logic [31:0] rd;
        bit m1seen;
        #3;
        reset_all();
        run = 1'b1;
        chk("reset_grant", 32'(a_grant), 32'd0);
        chk("reset_s_valid", 32'(a_s_valid), 32'd0);
        chk("reset_bus_err", 32'(a_bus_err), 32'd0);
        chk("reset_err_addr", a_err_addr, 32'd0);

        // single master read, slave acks on the third granted cycle
        s_rdata = 32'h1234_5678; slave_en = 1'b1; slave_lat = 2; slave_sel = 1'b0;
        m0_addr = 32'h0000_0100; m0_wstrb = 4'h0;
        m0_valid = 1'b1;
        #1;
        chk("t1_pre_grant", 32'(a_grant), 32'd0);
        tick();
        chk("t1_grant", 32'(a_grant), 32'd1);
        chk("t1_s_valid", 32'(a_s_valid), 32'd1);
        chk("t1_s_addr", a_s_addr, 32'h0000_0100);
        nrdy = 0; at = -1; m1seen = 1'b0; rd = '0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (a_m0_ready) begin
                nrdy++;
                if (at < 0) begin at = i; rd = a_m0_rdata; end
            end
            if (a_m1_ready) m1seen = 1'b1;
            tick();
            if (at >= 0) m0_valid = 1'b0;
        end
        chk("t1_ready_at", 32'(at), 32'd2);
        chk("t1_ready_count", 32'(nrdy), 32'd1);
        chk("t1_rdata", rd, 32'h1234_5678);
        chk("t1_m1_ready", 32'(m1seen), 32'd0);

        // contention: round robin alternates, fixed priority always serves m0
        m0_wdata = 32'h1111_1111; m0_wstrb = 4'hF;
        m1_addr = 32'h0000_0200; m1_wdata = 32'h0000_A5A5; m1_wstrb = 4'h3;
        reset_all();
        slave_en = 1'b1; slave_lat = 1; slave_sel = 1'b0;
        run_contention(1'b0);
        chk("t2_rr_g0", 32'(gseq[0]), 32'd1);
        chk("t2_rr_g1", 32'(gseq[1]), 32'd2);
        chk("t2_rr_g2", 32'(gseq[2]), 32'd1);
        chk("t2_rr_g3", 32'(gseq[3]), 32'd2);
        reset_all();
        slave_en = 1'b1; slave_lat = 1; slave_sel = 1'b1;
        run_contention(1'b1);
        for (int i = 0; i < 4; i++) chk($sformatf("t2_fp_g%0d", i), 32'(gseq[i]), 32'd1);
        chk("t2_fp_m1_grants", 32'(m1_grants), 32'd0);

        // late arrival of m1 during an m0 transfer
        reset_all();
        slave_sel = 1'b0; slave_en = 1'b1; slave_lat = 3; s_rdata = 32'h0000_0A0A;
        m0_addr = 32'h0000_0100; m0_wstrb = 4'h0; m1_wstrb = 4'h0;
        m0_valid = 1'b1;
        tick();
        m1_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!a_m0_ready && n < 20) begin
            chk("t3_s_addr", a_s_addr, 32'h0000_0100);
            n++;
            @(negedge clk);
        end
        chk("t3_s_addr_done", a_s_addr, 32'h0000_0100);
        chk("t3_m0_wait", 32'(n), 32'd3);
        tick();
        m0_valid = 1'b0;
        @(negedge clk);
        chk("t3_idle_gap", 32'(a_grant), 32'd0);
        @(negedge clk);
        chk("t3_m1_grant", 32'(a_grant), 32'd2);
        chk("t3_m1_addr", a_s_addr, 32'h0000_0200);
        wait_done(1'b1, n, rd);
        chk("t3_m1_wait", 32'(n), 32'd2);

        // timeout on an unmapped read, then a second timeout keeps the first address
        slave_en = 1'b0;
        m1_addr = 32'h9000_0000;
        m1_valid = 1'b1;
        tick();
        wait_done(1'b1, n, rd);
        chk("t4_to_cycle", 32'(n), 32'd7);
        chk("t4_to_rdata", rd, 32'hDEAD_BEEF);
        chk("t4_bus_err", 32'(a_bus_err), 32'd1);
        chk("t4_err_addr", a_err_addr, 32'h9000_0000);
        m1_addr = 32'h9000_0004;
        m1_valid = 1'b1;
        tick();
        wait_done(1'b1, n, rd);
        chk("t4_to2_cycle", 32'(n), 32'd7);
        chk("t4_to2_rdata", rd, 32'hDEAD_BEEF);
        chk("t4_err_addr_kept", a_err_addr, 32'h9000_0000);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("t4_clr_bus_err", 32'(a_bus_err), 32'd0);
        chk("t4_clr_err_addr", a_err_addr, 32'd0);

        // slave ready on the last allowed cycle is a normal completion
        slave_en = 1'b1; slave_lat = 7; s_rdata = 32'hCAFE_0001;
        m0_addr = 32'h0000_0100;
        m0_valid = 1'b1;
        tick();
        wait_done(1'b0, n, rd);
        chk("t5_limit_cycle", 32'(n), 32'd7);
        chk("t5_limit_rdata", rd, 32'hCAFE_0001);
        chk("t5_limit_bus_err", 32'(a_bus_err), 32'd0);

        // err_clr in the same cycle as a new timeout: set wins with the new address
        slave_en = 1'b0;
        m1_addr = 32'h9000_0008;
        m1_valid = 1'b1;
        tick();
        wait_done(1'b1, n, rd);
        chk("t6_err_addr_first", a_err_addr, 32'h9000_0008);
        m1_addr = 32'h9000_000C;
        m1_valid = 1'b1;
        tick();
        repeat (7) tick();
        err_clr = 1'b1;
        @(negedge clk);
        chk("t6_to_ready", 32'(a_m1_ready), 32'd1);
        tick();
        err_clr = 1'b0;
        m1_valid = 1'b0;
        chk("t6_bus_err", 32'(a_bus_err), 32'd1);
        chk("t6_err_addr_new", a_err_addr, 32'h9000_000C);

        // asynchronous reset in the middle of a granted transfer
        m0_addr = 32'h0000_0100;
        m0_valid = 1'b1;
        tick();
        tick();
        chk("t7_pre_s_valid", 32'(a_s_valid), 32'd1);
        #1;
        reset_n = 1'b0;
        #1;
        chk("t7_rst_s_valid", 32'(a_s_valid), 32'd0);
        chk("t7_rst_grant", 32'(a_grant), 32'd0);
        chk("t7_rst_m0_ready", 32'(a_m0_ready), 32'd0);
        chk("t7_rst_bus_err", 32'(a_bus_err), 32'd0);
        chk("t7_rst_err_addr", a_err_addr, 32'd0);
        tick();
        reset_n = 1'b1;
        slave_en = 1'b1; slave_lat = 0; s_rdata = 32'h0BAD_F00D;
        tick();
        chk("t7_regrant", 32'(a_grant), 32'd1);
        wait_done(1'b0, n, rd);
        chk("t7_after_wait", 32'(n), 32'd0);
        chk("t7_after_rdata", rd, 32'h0BAD_F00D);
        tick();
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "simulation time limit");
    end
endmodule
